// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe
// Purpose  : Decode-to-execute pipeline register with load-use hazard
//            detection and branch/jump flush control.
//            The E register is never held: a load-use hazard stalls fetch
//            and decode and injects a bubble into E. A taken branch or jump
//            resolved in execute (PCSrc_E) flushes D and E, and it wins over
//            a simultaneous load-use hazard.
// Ports    : clk, rst (synchronous, active-high)
//            valid_D, rs1_D, rs2_D, rd_D, ctrl_D, RD1_D, RD2_D, Imm_D,
//            PC_D, PCPlus4_D  -> decode-stage inputs
//            PCSrc_E          -> taken branch/jump from execute
//            valid_E, rs1_E, rs2_E, rd_E, ctrl_E, RD1_E, RD2_E, Imm_E,
//            PC_E, PCPlus4_E  -> registered execute-stage copies
//            stall_F, stall_D, flush_D, flush_E -> combinational controls
//            stall_cnt        -> stall-cycle counter (ID_EX_PERF_CNT_EN only)
// Options  : define ID_EX_PERF_CNT_EN to add the saturating stall counter.
// ctrl bits: [0]RegWrite [1]MemRead [2]MemWrite [3]ALUSrc [4]Branch
//            [5]Jump [9:6]ALUControl
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_D,
    input  logic [4:0]      rs1_D,
    input  logic [4:0]      rs2_D,
    input  logic [4:0]      rd_D,
    input  logic [9:0]      ctrl_D,
    input  logic [XLEN-1:0] RD1_D,
    input  logic [XLEN-1:0] RD2_D,
    input  logic [XLEN-1:0] Imm_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] PCPlus4_D,
    input  logic            PCSrc_E,
    output logic            valid_E,
    output logic [4:0]      rs1_E,
    output logic [4:0]      rs2_E,
    output logic [4:0]      rd_E,
    output logic [9:0]      ctrl_E,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_E,
    output logic [XLEN-1:0] PC_E,
    output logic [XLEN-1:0] PCPlus4_E,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]     stall_cnt,
`endif
    output logic            stall_F,
    output logic            stall_D,
    output logic            flush_D,
    output logic            flush_E
);

    // RegWrite and MemWrite: the bits that cause architectural side effects.
    localparam logic [9:0] c_SIDE_EFFECT_MASK = 10'b00_0000_0101;

    logic            r_valid;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [9:0]      r_ctrl;
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;

    logic            w_lu_hazard;
    logic            w_flush_e;
    logic [9:0]      w_ctrl_capture;

    // A load in E whose destination is read by the valid instruction in D.
    // x0 never creates a dependency.
    assign w_lu_hazard = r_valid & r_ctrl[1] & (r_rd != 5'd0) & valid_D &
                         ((r_rd == rs1_D) | (r_rd == rs2_D));

    assign w_flush_e = PCSrc_E | w_lu_hazard;

    // Hazard controls are silenced during reset. A taken branch squashes
    // the stall: the dependent instruction is being flushed anyway.
    assign stall_F = ~rst & w_lu_hazard & ~PCSrc_E;
    assign stall_D = ~rst & w_lu_hazard & ~PCSrc_E;
    assign flush_D = ~rst & PCSrc_E;
    assign flush_E = ~rst & w_flush_e;

    // An invalid instruction may still travel down the pipe, but it must
    // never write the register file or memory.
    assign w_ctrl_capture = valid_D ? ctrl_D : (ctrl_D & ~c_SIDE_EFFECT_MASK);

    // The bubble (all zeros) has RegWrite=0 and rd=0, so it can never be
    // picked up by downstream forwarding, and it clears the load-use hazard
    // on the following cycle.
    always_ff @(posedge clk) begin
        if (rst || w_flush_e) begin
            r_valid    <= 1'b0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_ctrl     <= 10'd0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
        end else begin
            r_valid    <= valid_D;
            r_rs1      <= rs1_D;
            r_rs2      <= rs2_D;
            r_rd       <= rd_D;
            r_ctrl     <= w_ctrl_capture;
            r_rd1      <= RD1_D;
            r_rd2      <= RD2_D;
            r_imm      <= Imm_D;
            r_pc       <= PC_D;
            r_pc_plus4 <= PCPlus4_D;
        end
    end

    assign valid_E   = r_valid;
    assign rs1_E     = r_rs1;
    assign rs2_E     = r_rs2;
    assign rd_E      = r_rd;
    assign ctrl_E    = r_ctrl;
    assign RD1_E     = r_rd1;
    assign RD2_E     = r_rd2;
    assign Imm_E     = r_imm;
    assign PC_E      = r_pc;
    assign PCPlus4_E = r_pc_plus4;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturates instead of wrapping so a long run never reports a small count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (stall_D && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe
// Purpose  : Directed self-checking bench for id_ex_pipe: reset state,
//            normal capture, load-use stall and bubble, x0 load, invalid
//            instruction masking, branch priority over stall, reset during
//            a stall. Stall counter checks are active with ID_EX_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_D;
    logic [4:0]      rs1_D, rs2_D, rd_D;
    logic [9:0]      ctrl_D;
    logic [XLEN-1:0] RD1_D, RD2_D, Imm_D, PC_D, PCPlus4_D;
    logic            PCSrc_E;
    logic            valid_E;
    logic [4:0]      rs1_E, rs2_E, rd_E;
    logic [9:0]      ctrl_E;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_E, PC_E, PCPlus4_E;
    logic            stall_F, stall_D, flush_D, flush_E;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    id_ex_pipe #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_D   (valid_D),
        .rs1_D     (rs1_D),
        .rs2_D     (rs2_D),
        .rd_D      (rd_D),
        .ctrl_D    (ctrl_D),
        .RD1_D     (RD1_D),
        .RD2_D     (RD2_D),
        .Imm_D     (Imm_D),
        .PC_D      (PC_D),
        .PCPlus4_D (PCPlus4_D),
        .PCSrc_E   (PCSrc_E),
        .valid_E   (valid_E),
        .rs1_E     (rs1_E),
        .rs2_E     (rs2_E),
        .rd_E      (rd_E),
        .ctrl_E    (ctrl_E),
        .RD1_E     (RD1_E),
        .RD2_E     (RD2_E),
        .Imm_E     (Imm_E),
        .PC_E      (PC_E),
        .PCPlus4_E (PCPlus4_E),
`ifdef ID_EX_PERF_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .stall_F   (stall_F),
        .stall_D   (stall_D),
        .flush_D   (flush_D),
        .flush_E   (flush_E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [9:0] c, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc);
        valid_D   = v;
        ctrl_D    = c;
        rs1_D     = r1;
        rs2_D     = r2;
        rd_D      = rd;
        RD1_D     = d1;
        RD2_D     = d2;
        Imm_D     = imm;
        PC_D      = pc;
        PCPlus4_D = pc + 32'd4;
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid_E"}, 64'(valid_E), 64'd0);
        chk({tag, ".ctrl_E"},  64'(ctrl_E),  64'd0);
        chk({tag, ".rd_E"},    64'(rd_E),    64'd0);
        chk({tag, ".rs1_E"},   64'(rs1_E),   64'd0);
        chk({tag, ".rs2_E"},   64'(rs2_E),   64'd0);
        chk({tag, ".RD1_E"},   64'(RD1_E),   64'd0);
        chk({tag, ".RD2_E"},   64'(RD2_E),   64'd0);
        chk({tag, ".Imm_E"},   64'(Imm_E),   64'd0);
        chk({tag, ".PC_E"},    64'(PC_E),    64'd0);
        chk({tag, ".PC4_E"},   64'(PCPlus4_E), 64'd0);
    endtask

    task automatic chk_ctl(input string tag, input logic sf, input logic sd,
                           input logic fd, input logic fe);
        chk({tag, ".stall_F"}, 64'(stall_F), 64'(sf));
        chk({tag, ".stall_D"}, 64'(stall_D), 64'(sd));
        chk({tag, ".flush_D"}, 64'(flush_D), 64'(fd));
        chk({tag, ".flush_E"}, 64'(flush_E), 64'(fe));
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef ID_EX_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(exp));
`else
        if (exp == 32'hDEAD_BEEF) $display("unused %s", tag);
`endif
    endtask

    initial begin
        // Reset with a hazard-like pattern and PCSrc_E high: outputs silent.
        rst     = 1'b1;
        PCSrc_E = 1'b1;
        set_d(1'b1, 10'h003, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h100);
        step();
        chk_bubble("reset");
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("reset", 32'd0);

        // Basic capture, one cycle latency.
        rst     = 1'b0;
        PCSrc_E = 1'b0;
        set_d(1'b1, 10'h001, 5'd1, 5'd2, 5'd5, 32'h1234, 32'h5678, 32'h9, 32'h200);
        chk_ctl("cap_pre", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("cap.rd_E",    64'(rd_E),    64'd5);
        chk("cap.RD1_E",   64'(RD1_E),   64'h1234);
        chk("cap.RD2_E",   64'(RD2_E),   64'h5678);
        chk("cap.Imm_E",   64'(Imm_E),   64'h9);
        chk("cap.PC_E",    64'(PC_E),    64'h200);
        chk("cap.PC4_E",   64'(PCPlus4_E), 64'h204);
        chk("cap.rs1_E",   64'(rs1_E),   64'd1);
        chk("cap.rs2_E",   64'(rs2_E),   64'd2);
        chk("cap.valid_E", 64'(valid_E), 64'd1);
        chk("cap.ctrl_E",  64'(ctrl_E),  64'h001);
        chk_ctl("cap_post", 1'b0, 1'b0, 1'b0, 1'b0);

        // Load rd=7 into E, then a consumer reading x7 through rs2.
        set_d(1'b1, 10'h003, 5'd3, 5'd4, 5'd7, 32'h11, 32'h22, 32'h33, 32'h300);
        step();
        chk("ld.ctrl_E", 64'(ctrl_E), 64'h003);
        set_d(1'b1, 10'h001, 5'd3, 5'd7, 5'd8, 32'hAB, 32'hCD, 32'hEF, 32'h304);
        chk_ctl("lu", 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk_bubble("lu_bubble");
        chk_ctl("lu_after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("lu", 32'd1);
        step();
        chk("lu_retry.rd_E",    64'(rd_E),    64'd8);
        chk("lu_retry.valid_E", 64'(valid_E), 64'd1);
        chk("lu_retry.RD2_E",   64'(RD2_E),   64'hCD);

        // Load to x0 never stalls.
        set_d(1'b1, 10'h003, 5'd1, 5'd1, 5'd0, 32'h1, 32'h2, 32'h3, 32'h400);
        step();
        set_d(1'b1, 10'h001, 5'd0, 5'd0, 5'd9, 32'hAAAA, 32'hBBBB, 32'h4, 32'h404);
        chk_ctl("x0", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("x0.rd_E",  64'(rd_E),  64'd9);
        chk("x0.RD1_E", 64'(RD1_E), 64'hAAAA);

        // Invalid instruction: RegWrite and MemWrite masked, rest captured.
        set_d(1'b0, 10'h3FF, 5'd4, 5'd4, 5'd4, 32'h5, 32'h6, 32'h7, 32'h500);
        step();
        chk("inv.ctrl_E",  64'(ctrl_E),  64'h3FA);
        chk("inv.valid_E", 64'(valid_E), 64'd0);
        chk("inv.rd_E",    64'(rd_E),    64'd4);
        // An invalid load in E must not create a hazard.
        set_d(1'b1, 10'h001, 5'd4, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 32'h504);
        chk_ctl("inv_ld", 1'b0, 1'b0, 1'b0, 1'b0);

        // Valid load, but invalid consumer in D: no stall.
        set_d(1'b1, 10'h003, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 32'h600);
        step();
        set_d(1'b0, 10'h001, 5'd6, 5'd6, 5'd2, 32'h0, 32'h0, 32'h0, 32'h604);
        chk_ctl("inv_use", 1'b0, 1'b0, 1'b0, 1'b0);

        // Load-use plus taken branch: branch wins, no stall counted.
        set_d(1'b1, 10'h001, 5'd6, 5'd1, 5'd2, 32'h77, 32'h0, 32'h0, 32'h604);
        chk_ctl("lu_only", 1'b1, 1'b1, 1'b0, 1'b1);
        PCSrc_E = 1'b1;
        #1;
        chk_ctl("lu_br", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_bubble("lu_br_bubble");
        chk_cnt("lu_br", 32'd1);
        PCSrc_E = 1'b0;

        // Plain branch flush of a non-hazard instruction.
        set_d(1'b1, 10'h001, 5'd1, 5'd2, 5'd3, 32'h9, 32'h9, 32'h9, 32'h700);
        PCSrc_E = 1'b1;
        #1;
        chk_ctl("br", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_bubble("br_bubble");
        PCSrc_E = 1'b0;

        // Reset asserted in the middle of a stall.
        set_d(1'b1, 10'h003, 5'd0, 5'd0, 5'd10, 32'h1, 32'h2, 32'h3, 32'h800);
        step();
        set_d(1'b1, 10'h001, 5'd1, 5'd10, 5'd11, 32'h4, 32'h5, 32'h6, 32'h804);
        chk_ctl("rst_stall_pre", 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk_ctl("rst_stall", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_bubble("rst_stall_bubble");
        chk_cnt("rst_stall", 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst.rd_E", 64'(rd_E), 64'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_D  input  1  decode stage holds a real instruction.
REQ-005 SHALL have ports rs1_D, rs2_D, rd_D  input  5 each  decoded register indices.
REQ-006 SHALL have port ctrl_D  input  10  [0]RegWrite [1]MemRead [2]MemWrite [3]ALUSrc [4]Branch [5]Jump [9:6]ALUControl.
REQ-007 SHALL have ports RD1_D, RD2_D, Imm_D, PC_D, PCPlus4_D  input  XLEN each  decode datapath values.
REQ-008 SHALL have port PCSrc_E  input  1  taken branch/jump resolved in execute.
REQ-009 SHALL have outputs valid_E (1), rs1_E/rs2_E/rd_E (5 each), ctrl_E (10), RD1_E/RD2_E/Imm_E/PC_E/PCPlus4_E (XLEN each): registered execute-stage copies.
REQ-010 SHALL have outputs stall_F, stall_D, flush_D, flush_E  1 each  combinational hazard controls.
REQ-011 SHALL have output stall_cnt  32, present only when ID_EX_PERF_CNT_EN is defined.

Function
REQ-012 SHALL compute lu_hazard = valid_E & ctrl_E[1] & (rd_E!=0) & valid_D & (rd_E==rs1_D | rd_E==rs2_D).
REQ-013 SHALL drive stall_F = stall_D = lu_hazard & ~PCSrc_E.
REQ-014 SHALL drive flush_D = PCSrc_E.
REQ-015 SHALL drive flush_E = PCSrc_E | lu_hazard.
REQ-016 SHALL, on rising edge with flush_E=1, load a bubble: valid_E=0, ctrl_E=0, rs1_E=rs2_E=rd_E=0, all XLEN outputs 0.
REQ-017 SHALL, on rising edge with flush_E=0, capture all _D inputs into corresponding _E outputs, valid_E=valid_D; latency exactly 1 cycle.
REQ-018 SHALL never hold the E register; stall affects only upstream stages.
REQ-019 SHALL, for an invalid instruction captured (valid_D=0), still force ctrl_E[0], ctrl_E[2] to 0 so no architectural side effect occurs.
REQ-020 SHALL give PCSrc_E priority over lu_hazard when both are asserted: no stall, both flushes asserted.
REQ-021 SHALL guarantee a bubble never matches downstream forwarding (RegWrite_E=0, rd_E=0).
REQ-022 SHALL produce exactly one stall cycle per load-use hazard; following cycle the bubble clears lu_hazard.

Reset
REQ-023 SHALL, while rst=1 at a rising edge, load the bubble state of REQ-016, overriding all other inputs.
REQ-024 SHALL force stall_F, stall_D, flush_D, flush_E to 0 while rst=1.
REQ-025 SHALL reset stall_cnt to 0 when present; reset asserted mid-stall aborts the stall immediately.

Configuration
REQ-026 SHALL, with ID_EX_PERF_CNT_EN defined, increment stall_cnt by 1 each cycle stall_D=1, saturating at 32'hFFFF_FFFF.
REQ-027 SHALL, without ID_EX_PERF_CNT_EN, omit stall_cnt port and counter logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: ctrl_D=10'h001, rd_D=5, RD1_D=32'h1234, valid_D=1 -> next cycle rd_E=5, RD1_E=32'h1234, valid_E=1, no stall.
REQ-029 SHALL cover: E holds load rd_E=7, D has rs2_D=7 -> stall_F=stall_D=flush_E=1 one cycle, then bubble (ctrl_E=0), stall drops, stall_cnt=1.
REQ-030 SHALL cover: load rd_E=0, rs1_D=0 -> no stall, normal capture.
REQ-031 SHALL cover: load-use hazard plus PCSrc_E=1 same cycle -> stall_F=0, flush_D=1, flush_E=1, bubble next cycle, stall_cnt unchanged.
REQ-032 SHALL cover: rst=1 during a stall cycle -> hazard outputs 0 that cycle, valid_E=0, all _E outputs 0 next edge, stall_cnt=0.
